scaler_window_ctrl: RTL and testbench
=====================================

SCALER_WINDOW_CTRL -- requirements
Module: scaler_window_ctrl

Interface
REQ-001 SHALL have parameters: IMG_W, 64, frame width in pixels (multiple of 4); IMG_H, 48, frame height in rows (even); PIPE_LAT, 5, scaler cycles from issue to valid scl_tpix; FIFO_DEPTH, 8, output FIFO entries (power of 2).
REQ-002 SHALL have ports: clk in 1, sole clock. rst in 1, synchronous, active-high reset.
REQ-003 SHALL have ports: start in 1, begin frame. busy out 1, frame in progress. frame_done out 1, one-cycle pulse.
REQ-004 SHALL have ports: in_pix in 8, raster pixel. in_valid in 1. in_ready out 1.
REQ-005 SHALL have ports: t1..t4 out 8 each, top-row window. b1..b4 out 8 each, bottom-row window. scl_valid out 1, issue strobe. scl_tpix in 8, scaler result.
REQ-006 SHALL have ports: out_pix out 8. out_valid out 1. out_ready in 1. out_last out 1, final output of frame.

Function
REQ-007 SHALL implement FSM IDLE->FILL->SCAN->(FILL|DRAIN)->IDLE.
- IDLE: start moves to FILL. start while not IDLE is ignored.
REQ-008 FILL (even row): in_ready=1; each accepted pixel is written to line buffer[col]; col increments. After col IMG_W-1 is accepted: col wraps to 0 and the FSM moves to SCAN.
REQ-009 SCAN (odd row): accepted pixels go into a 4-entry bottom register. When the 4th pixel of group k is accepted, the next cycle SHALL drive:
- scl_valid=1;
- t1..t4 = linebuf[4k..4k+3];
- b1..b4 = the 4 bottom pixels, column order.
REQ-010 After the last pixel of an odd row, the FSM SHALL move to FILL, or to DRAIN if that row was row IMG_H-1.
REQ-011 t1..t4/b1..b4 SHALL hold their last issued values while scl_valid=0.
REQ-012 Each issue SHALL enter a PIPE_LAT-deep valid shift register. When a bit exits, scl_tpix SHALL be written to the output FIFO the same cycle.
REQ-013 Credit rule: in SCAN, in_ready=1 only while (fifo_count + inflight) < FIFO_DEPTH. The FIFO SHALL therefore never overflow; scl_tpix is never dropped.
REQ-014 in_ready SHALL be 0 in IDLE and DRAIN.
REQ-015 out_valid = FIFO non-empty; out_pix = FIFO head. An entry pops when out_valid and out_ready are both 1. A push and a pop in the same cycle leave fifo_count unchanged.
REQ-016 out_last SHALL be 1 with the (IMG_W/4)*(IMG_H/2)-th output of the frame.
REQ-017 DRAIN exits to IDLE when inflight=0 and the FIFO is empty. frame_done pulses on that transition.
REQ-018 busy=1 in all states except IDLE.

Reset
REQ-019 rst SHALL force:
- FSM to IDLE; col, group, inflight and FIFO pointers to 0;
- the shift register cleared, discarding any in-flight results;
- in_ready, scl_valid, out_valid, out_last, busy, frame_done to 0;
- t1..t4 and b1..b4 to 0.
REQ-020 Line buffer contents need not reset. rst mid-frame SHALL abort with no further outputs.

Configuration
REQ-021 Macro SCALER_CTRL_STATUS_EN defined: SHALL add output frame_cnt (16 bits, reset 0), incremented on each frame_done and wrapping at 65535->0. Undefined: the port and its counter are absent.

Verification
REQ-022 IMG_W=8, IMG_H=4, PIPE_LAT=5, out_ready=1, row0=0..7, row1=10..17 -> one cycle after pixel 13 is accepted: scl_valid=1, t1..t4=0,1,2,3, b1..b4=10,11,12,13.
REQ-023 Same config, scaler model returns t1+b1 -> out_pix sequence 10,18,50,58; out_last on the 4th output; frame_done the cycle after DRAIN empties.
REQ-024 out_ready=0 entire frame, FIFO_DEPTH=2 -> in_ready drops once count+inflight=2; no loss; after out_ready=1, all 4 outputs arrive in order.
REQ-025 rst asserted mid-SCAN -> next cycle busy=0, out_valid=0; the in-flight result never appears; a new start completes a normal frame.
REQ-026 start pulsed during FILL -> ignored; the frame completes with exactly 4 outputs.
REQ-027 With SCALER_CTRL_STATUS_EN defined, 3 back-to-back frames -> frame_cnt=3.

Source files
------------

// File: rtl/scaler_window_ctrl.sv
// Window controller for a 2-row scaler: buffers an even row, pairs it with the odd row in 4-pixel
// groups, issues 2x4 windows and queues results. Define SCALER_CTRL_STATUS_EN to add frame_cnt.

module scaler_window_lane (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] t_in,
  input  logic [7:0] b_in,
  output logic [7:0] t_q,
  output logic [7:0] b_q
);
  logic [7:0] t_d, b_d;

  always_comb begin
    t_d = t_q;
    b_d = b_q;
    if (load) begin
      t_d = t_in;
      b_d = b_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      t_q <= '0;
      b_q <= '0;
    end else begin
      t_q <= t_d;
      b_q <= b_d;
    end
  end
endmodule

module scaler_window_ctrl #(
  parameter int IMG_W      = 64,
  parameter int IMG_H      = 48,
  parameter int PIPE_LAT   = 5,
  parameter int FIFO_DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       busy,
  output logic       frame_done,
  input  logic [7:0] in_pix,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] t1,
  output logic [7:0] t2,
  output logic [7:0] t3,
  output logic [7:0] t4,
  output logic [7:0] b1,
  output logic [7:0] b2,
  output logic [7:0] b3,
  output logic [7:0] b4,
  output logic       scl_valid,
  input  logic [7:0] scl_tpix,
  output logic [7:0] out_pix,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_last
`ifdef SCALER_CTRL_STATUS_EN
  ,
  output logic [15:0] frame_cnt
`endif
);
  localparam int NUM_LANES = 4;
  localparam int CW        = $clog2(IMG_W);
  localparam int RW        = $clog2(IMG_H);
  localparam int FW        = $clog2(FIFO_DEPTH);
  localparam int KW        = $clog2(FIFO_DEPTH + 1);
  localparam int TOTAL     = (IMG_W / 4) * (IMG_H / 2);
  localparam int OW        = $clog2(TOTAL + 1);

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_SCAN, S_DRAIN} state_e;

  state_e                        state_q, state_d;
  logic [CW-1:0]                 col_q, col_d;
  logic [RW-1:0]                 row_q, row_d;
  logic [NUM_LANES-2:0][7:0]     bot_q, bot_d;
  logic [KW-1:0]                 inflight_q, inflight_d;
  logic [KW-1:0]                 cnt_q, cnt_d;
  logic [FW-1:0]                 wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [OW-1:0]                 out_cnt_q, out_cnt_d;
  logic                          scl_valid_q, scl_valid_d;
  logic                          frame_done_q, frame_done_d;
  logic [PIPE_LAT-1:0]           vld_q, vld_d;
  logic [PIPE_LAT:0]             vld_pipe;

  logic [7:0]                    linebuf_mem [IMG_W];
  logic [7:0]                    fifo_mem    [FIFO_DEPTH];

  logic accept, grp_last, row_last, issue, push, pop;
  logic [NUM_LANES-1:0][7:0] t_win, b_win;

  // vld_pipe[k] is high k cycles after an issue; the top bit marks scl_tpix as valid.
  assign vld_pipe = {vld_q, scl_valid_q};
  assign push     = vld_pipe[PIPE_LAT];
  assign pop      = out_valid && out_ready;
  assign accept   = in_valid && in_ready;
  assign grp_last = (col_q[1:0] == 2'd3);
  assign row_last = (col_q == CW'(IMG_W - 1));
  assign issue    = accept && (state_q == S_SCAN) && grp_last;

  // Credit counts issues from acceptance onward so a full FIFO plus pipeline can never overflow.
  always_comb begin
    in_ready = 1'b0;
    case (state_q)
      S_FILL:  in_ready = 1'b1;
      S_SCAN:  in_ready = ({1'b0, cnt_q} + {1'b0, inflight_q}) < (KW + 1)'(FIFO_DEPTH);
      default: in_ready = 1'b0;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    col_d        = col_q;
    row_d        = row_q;
    bot_d        = bot_q;
    frame_done_d = 1'b0;
    case (state_q)
      S_IDLE: if (start) begin
        state_d = S_FILL;
        col_d   = '0;
        row_d   = '0;
      end
      S_FILL: if (accept) begin
        col_d = row_last ? '0 : col_q + 1'b1;
        if (row_last) begin
          row_d   = row_q + 1'b1;
          state_d = S_SCAN;
        end
      end
      S_SCAN: if (accept) begin
        for (int i = 0; i < NUM_LANES - 1; i++)
          if (col_q[1:0] == 2'(i)) bot_d[i] = in_pix;
        col_d = row_last ? '0 : col_q + 1'b1;
        if (row_last) begin
          if (row_q == RW'(IMG_H - 1)) begin
            state_d = S_DRAIN;
            row_d   = '0;
          end else begin
            state_d = S_FILL;
            row_d   = row_q + 1'b1;
          end
        end
      end
      S_DRAIN: if (inflight_q == '0 && cnt_q == '0) begin
        state_d      = S_IDLE;
        frame_done_d = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    scl_valid_d = issue;
    vld_d       = vld_pipe[PIPE_LAT-1:0];
    inflight_d  = inflight_q + KW'(issue) - KW'(push);
    cnt_d       = cnt_q + KW'(push) - KW'(pop);
    wr_ptr_d    = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d    = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    out_cnt_d   = out_cnt_q;
    if (pop) out_cnt_d = (out_cnt_q == OW'(TOTAL - 1)) ? '0 : out_cnt_q + 1'b1;
    if (state_q == S_IDLE && start) out_cnt_d = '0;
  end

`ifdef SCALER_CTRL_STATUS_EN
  logic [15:0] frame_cnt_q, frame_cnt_d;
  always_comb frame_cnt_d = frame_cnt_q + 16'(frame_done_d);
  always_ff @(posedge clk) begin
    if (rst) frame_cnt_q <= '0;
    else     frame_cnt_q <= frame_cnt_d;
  end
  assign frame_cnt = frame_cnt_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      col_q        <= '0;
      row_q        <= '0;
      bot_q        <= '0;
      inflight_q   <= '0;
      cnt_q        <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      out_cnt_q    <= '0;
      scl_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      vld_q        <= '0;
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      row_q        <= row_d;
      bot_q        <= bot_d;
      inflight_q   <= inflight_d;
      cnt_q        <= cnt_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      out_cnt_q    <= out_cnt_d;
      scl_valid_q  <= scl_valid_d;
      frame_done_q <= frame_done_d;
      vld_q        <= vld_d;
    end
  end

  // Storage arrays carry no reset; pointers and counts define their validity.
  always_ff @(posedge clk) begin
    if (accept && state_q == S_FILL) linebuf_mem[col_q] <= in_pix;
    if (push) fifo_mem[wr_ptr_q] <= scl_tpix;
  end

  // The 4th bottom pixel comes straight from in_pix so the window is issued the cycle after it.
  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    logic [CW-1:0] idx;
    logic [7:0]    b_in;
    assign idx = (col_q & ~CW'(3)) | CW'(i);
    if (i == NUM_LANES - 1) begin : g_live
      assign b_in = in_pix;
    end else begin : g_held
      assign b_in = bot_q[i];
    end
    scaler_window_lane u_lane (
      .clk  (clk),
      .rst  (rst),
      .load (issue),
      .t_in (linebuf_mem[idx]),
      .b_in (b_in),
      .t_q  (t_win[i]),
      .b_q  (b_win[i])
    );
  end

  assign {t4, t3, t2, t1} = t_win;
  assign {b4, b3, b2, b1} = b_win;
  assign scl_valid  = scl_valid_q;
  assign frame_done = frame_done_q;
  assign busy       = (state_q != S_IDLE);
  assign out_valid  = (cnt_q != '0);
  assign out_pix    = fifo_mem[rd_ptr_q];
  assign out_last   = out_valid && (out_cnt_q == OW'(TOTAL - 1));
endmodule

// File: tb/tb_scaler_window_ctrl.sv
// Directed bench for scaler_window_ctrl on an 8x4 frame with a 2-entry FIFO; the scaler is
// modelled as t1+b1 delayed PIPE_LAT cycles.

module tb_scaler_window_ctrl;
  localparam int IMG_W = 8, IMG_H = 4, PIPE_LAT = 5, FIFO_DEPTH = 2;

  logic clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic busy, frame_done, in_valid = 1'b0, in_ready, scl_valid, out_valid, out_last;
  logic out_ready = 1'b1;
  logic [7:0] in_pix = '0, t1, t2, t3, t4, b1, b2, b3, b4, scl_tpix, out_pix;
`ifdef SCALER_CTRL_STATUS_EN
  logic [15:0] frame_cnt;
`endif

  always #5 clk = ~clk;

  scaler_window_ctrl #(.IMG_W(IMG_W), .IMG_H(IMG_H), .PIPE_LAT(PIPE_LAT), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .frame_done(frame_done),
    .in_pix(in_pix), .in_valid(in_valid), .in_ready(in_ready),
    .t1(t1), .t2(t2), .t3(t3), .t4(t4), .b1(b1), .b2(b2), .b3(b3), .b4(b4),
    .scl_valid(scl_valid), .scl_tpix(scl_tpix),
    .out_pix(out_pix), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last)
`ifdef SCALER_CTRL_STATUS_EN
    , .frame_cnt(frame_cnt)
`endif
  );

  logic [7:0] sp [1:PIPE_LAT];
  always @(posedge clk) begin
    sp[1] <= 8'(t1 + b1);
    for (int k = 2; k <= PIPE_LAT; k++) sp[k] <= sp[k-1];
  end
  assign scl_tpix = sp[PIPE_LAT];

  typedef struct packed {logic [7:0] t1, t2, t3, t4, b1, b2, b3, b4;} win_t;
  typedef struct packed {logic [7:0] base; win_t w; logic [7:0] o;} vec_t;

  win_t       wq [$];
  logic [7:0] oq [$];
  logic       lq [$];

  always @(negedge clk) begin
    if (out_valid && out_ready) begin
      oq.push_back(out_pix);
      lq.push_back(out_last);
    end
    if (scl_valid) wq.push_back({t1, t2, t3, t4, b1, b2, b3, b4});
  end

  int n_chk = 0, n_err = 0;
  vec_t vt [8];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_pix(input logic [7:0] p);
    logic acc;
    int   n;
    acc = 1'b0;
    n = 0;
    in_pix = p;
    in_valid = 1'b1;
    while (!acc && n < 300) begin
      acc = in_ready;
      tick();
      n++;
    end
    in_valid = 1'b0;
    if (!acc) chk("in_ready timeout", 0, 1);
  endtask

  task automatic send_rows(input logic [7:0] base, input int r0, input int r1,
                           input bit chk22, input bit pulse);
    for (int r = r0; r <= r1; r++)
      for (int c = 0; c < IMG_W; c++) begin
        if (pulse && r == 0 && c == 2) start = 1'b1;
        send_pix(8'(base + r * 10 + c));
        start = 1'b0;
        if (chk22 && r == 1 && c == 2) chk("no issue before group end", scl_valid, 0);
        if (chk22 && r == 1 && c == 3) begin
          chk("issue after pixel 13", scl_valid, 1);
          chk("first window", {t1, t2, t3, t4, b1, b2, b3, b4}, vt[0].w);
        end
      end
  endtask

  task automatic start_frame();
    wq.delete();
    oq.delete();
    lq.delete();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("busy after start", busy, 1);
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!frame_done && n < 500) begin
      tick();
      n++;
    end
    chk("frame_done seen", frame_done, 1);
    chk("busy at frame_done", busy, 0);
    chk("fifo empty at frame_done", out_valid, 0);
    tick();
    chk("frame_done one cycle", frame_done, 0);
  endtask

  task automatic check_frame(input int off);
    chk("issue count", wq.size(), 4);
    chk("output count", oq.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < wq.size()) chk($sformatf("window %0d", off + i), wq[i], vt[off+i].w);
      if (i < oq.size()) begin
        chk($sformatf("out_pix %0d", off + i), oq[i], vt[off+i].o);
        chk($sformatf("out_last %0d", off + i), lq[i], (i == 3));
      end
    end
  endtask

  initial begin
    vt[0] = '{8'd0,   '{8'd0,   8'd1,   8'd2,   8'd3,   8'd10,  8'd11,  8'd12,  8'd13},  8'd10};
    vt[1] = '{8'd0,   '{8'd4,   8'd5,   8'd6,   8'd7,   8'd14,  8'd15,  8'd16,  8'd17},  8'd18};
    vt[2] = '{8'd0,   '{8'd20,  8'd21,  8'd22,  8'd23,  8'd30,  8'd31,  8'd32,  8'd33},  8'd50};
    vt[3] = '{8'd0,   '{8'd24,  8'd25,  8'd26,  8'd27,  8'd34,  8'd35,  8'd36,  8'd37},  8'd58};
    vt[4] = '{8'd100, '{8'd100, 8'd101, 8'd102, 8'd103, 8'd110, 8'd111, 8'd112, 8'd113}, 8'd210};
    vt[5] = '{8'd100, '{8'd104, 8'd105, 8'd106, 8'd107, 8'd114, 8'd115, 8'd116, 8'd117}, 8'd218};
    vt[6] = '{8'd100, '{8'd120, 8'd121, 8'd122, 8'd123, 8'd130, 8'd131, 8'd132, 8'd133}, 8'd250};
    vt[7] = '{8'd100, '{8'd124, 8'd125, 8'd126, 8'd127, 8'd134, 8'd135, 8'd136, 8'd137}, 8'd258};

    repeat (3) tick();
    chk("reset busy", busy, 0);
    chk("reset in_ready", in_ready, 0);
    chk("reset scl_valid", scl_valid, 0);
    chk("reset out_valid", out_valid, 0);
    chk("reset out_last", out_last, 0);
    chk("reset frame_done", frame_done, 0);
    chk("reset windows", {t1, t2, t3, t4, b1, b2, b3, b4}, 64'h0);
`ifdef SCALER_CTRL_STATUS_EN
    chk("reset frame_cnt", frame_cnt, 0);
`endif
    rst = 1'b0;
    tick();

    // Frame A: plain frame, first-window timing.
    start_frame();
    send_rows(vt[0].base, 0, IMG_H - 1, 1'b1, 1'b0);
    wait_done();
    check_frame(0);

    // Frame B: start pulsed mid-FILL must be ignored.
    start_frame();
    send_rows(vt[4].base, 0, IMG_H - 1, 1'b0, 1'b1);
    wait_done();
    check_frame(4);

    // Frame C: output stalled, credit must stop input without losing results.
    out_ready = 1'b0;
    start_frame();
    send_rows(vt[0].base, 0, 2, 1'b0, 1'b0);
    repeat (12) tick();
    chk("credit stall in_ready", in_ready, 0);
    chk("stalled out_valid", out_valid, 1);
    chk("stalled head", out_pix, vt[0].o);
    chk("no pops while stalled", oq.size(), 0);
    out_ready = 1'b1;
    send_rows(vt[0].base, 3, 3, 1'b0, 1'b0);
    wait_done();
    check_frame(0);
`ifdef SCALER_CTRL_STATUS_EN
    chk("frame_cnt after 3 frames", frame_cnt, 3);
`endif

    // Reset while a window is in flight.
    start_frame();
    send_rows(vt[0].base, 0, 0, 1'b0, 1'b0);
    for (int c = 0; c < 4; c++) send_pix(8'(10 + c));
    tick();
    rst = 1'b1;
    tick();
    chk("mid-frame rst busy", busy, 0);
    chk("mid-frame rst out_valid", out_valid, 0);
    chk("mid-frame rst scl_valid", scl_valid, 0);
    chk("mid-frame rst in_ready", in_ready, 0);
    chk("mid-frame rst t1", t1, 0);
    rst = 1'b0;
    repeat (12) tick();
    chk("in-flight result discarded", oq.size(), 0);
    chk("still empty after rst", out_valid, 0);

    start_frame();
    send_rows(vt[4].base, 0, IMG_H - 1, 1'b0, 1'b0);
    wait_done();
    check_frame(4);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
